mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-port, fixed-latency memory between the pipeline's instruction-fetch requester (IF) and data-access requester (D, MEM stage).
- Arbitrates requests, issues one transaction at a time, and returns read data with a one-cycle ready pulse.
- Data access has priority; an anti-starvation counter guarantees forward progress of fetch.
- The pipeline derives its stall from req && !ready on each port.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from mem_en cycle to mem_rdata valid (>=1)
STARVE_LIM, 4, consecutive D grants with IF pending before IF is forced (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, held until if_ready
if_addr  in  ADDR_W  fetch address
if_ready  out  1  one-cycle completion pulse
if_rdata  out  DATA_W  fetched word, held until next IF completion
d_req  in  1  data request, held until d_ready
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_ready  out  1  one-cycle completion pulse
d_rdata  out  DATA_W  read word, held until next D read completion
mem_en  out  1  memory strobe, one cycle per transaction
mem_we  out  1  write strobe, only with mem_en
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  transaction in flight (state != IDLE)
owner  out  1  0 = IF, 1 = D; current/last grant

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0, state IDLE, starve_cnt 0. Applies mid-transaction: the in-flight transaction is abandoned, no ready pulse, later mem_rdata ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, no request: stay IDLE.
- IDLE, any request: choose winner; latch addr, we (IF always read), wdata and owner; go to ISSUE.
- ISSUE: mem_en=1, mem_we=latched we, exactly one cycle. Load wait counter with MEM_LAT-1; go to WAIT.
- WAIT: decrement each cycle. In the cycle the counter is 0, mem_rdata is valid: capture into if_rdata or d_rdata (reads only), then go to DONE.
- DONE: assert the owner's ready for one cycle; go to IDLE.
- Latency: req first seen in IDLE in cycle T gives ready in cycle T+2+MEM_LAT. Back-to-back transactions are spaced by the IDLE cycle (period MEM_LAT+3).
- Arbitration, both requests asserted in IDLE:
  - grant D, unless starve_cnt == STARVE_LIM, in which case grant IF.
  - D grant while if_req=1: starve_cnt += 1 (saturating at STARVE_LIM).
  - any IF grant, or D grant with if_req=0: starve_cnt = 0.
- Only one request asserted: grant it.
- Inputs are sampled only in IDLE. Changes on addr/wdata during a transaction have no effect.
- Request dropped mid-transaction (e.g. fetch flush): transaction still completes; ready still pulses and rdata still updates.
- Writes: identical timing. d_ready pulses and d_rdata is unchanged.
- mem_addr and mem_wdata hold their latched values outside ISSUE. mem_we=0 whenever mem_en=0.
- if_ready and d_ready are never high in the same cycle, and never high outside DONE.

Test Plan:
- Single fetch (MEM_LAT=2): if_req=1, if_addr=0x10 in cycle 0; bench drives mem_rdata=0xDEADBEEF in cycle 3 → mem_en=1, mem_addr=0x10 in cycle 1; if_ready=1, if_rdata=0xDEADBEEF in cycle 4; busy high in cycles 1-4.
- Simultaneous requests: if_req (0x20) and d_req read (0x80) both in cycle 0 → D issued cycle 1, d_ready cycle 4; IF issued cycle 6, if_ready cycle 9; owner 1 then 0.
- Write: d_req=1, d_we=1, addr 0x44, wdata 0x1234 → mem_en=mem_we=1, mem_wdata=0x1234 in cycle 1; d_ready cycle 4; d_rdata unchanged.
- Starvation with STARVE_LIM=2: if_req held, d_req held continuously → grant order D, D, IF, D, D, IF; if_ready occurs every third completion.
- Reset mid-operation: rst=1 in cycle 2 of a fetch → cycle 3 all outputs 0, state IDLE; no if_ready; the fetch re-issues after rst drops if if_req is still held.
- Flush drop: if_req deasserted in cycle 2 of a fetch → if_ready still pulses in cycle 4; the next IDLE cycle issues nothing.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port, fixed-latency memory between the instruction-fetch
//   requester (IF) and the data-access requester (D). One transaction is in
//   flight at a time. D has priority. A starvation counter forces an IF grant
//   after STARVE_LIM consecutive D grants made while IF was waiting.
//
//   Parameters:
//     ADDR_W     address width
//     DATA_W     data width
//     MEM_LAT    cycles from the mem_en cycle to mem_rdata valid (>= 1)
//     STARVE_LIM consecutive D grants with IF pending before IF is forced (>= 1)
//
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     if_req/if_addr              fetch request, held until if_ready
//     if_ready/if_rdata           fetch completion pulse / last fetched word
//     d_req/d_we/d_addr/d_wdata   data request, held until d_ready
//     d_ready/d_rdata             data completion pulse / last read word
//     mem_en/mem_we               memory strobe (one cycle per transaction) / write strobe
//     mem_addr/mem_wdata          latched address and write data
//     mem_rdata                   memory read data, valid MEM_LAT cycles after mem_en
//     busy                        transaction in flight
//     owner                       0 = IF, 1 = D; current or last grant
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_LIM + 1);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_MAX   = STV_W'(STARVE_LIM);

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [STV_W-1:0]   starve_cnt;
    logic               we_q;
    logic               grant_d;

    // D wins whenever it asks, except when IF has been passed over
    // STARVE_LIM times in a row and is still asking.
    assign grant_d = d_req && !(if_req && (starve_cnt == STV_MAX));

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            we_q       <= 1'b0;
            owner      <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            // Strobes and ready pulses are single-cycle; they are re-asserted
            // only on the transition that needs them.
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;

            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner    <= grant_d;
                        we_q     <= grant_d && d_we;
                        mem_addr <= grant_d ? d_addr : if_addr;
                        if (grant_d) begin
                            mem_wdata <= d_wdata;
                        end
                        // Count only D grants that actually made IF wait.
                        if (grant_d && if_req) begin
                            starve_cnt <= (starve_cnt == STV_MAX) ? STV_MAX
                                                                  : starve_cnt + 1'b1;
                        end else begin
                            starve_cnt <= '0;
                        end
                        // Strobe is registered, so it is high during ISSUE.
                        mem_en <= 1'b1;
                        mem_we <= grant_d && d_we;
                        state  <= ISSUE;
                    end
                end

                ISSUE: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= WAIT;
                end

                WAIT: begin
                    if (wait_cnt == '0) begin
                        // mem_rdata is valid this cycle; writes leave rdata alone.
                        if (!we_q) begin
                            if (owner) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                        if_ready <= !owner;
                        d_ready  <= owner;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with MEM_LAT=2, STARVE_LIM=2. A small
//   fixed-latency memory model returns a known word per address exactly
//   MEM_LAT cycles after the mem_en cycle and a poison value otherwise.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge;
//   "cycle k" is the k-th clock period after the test's start point.
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_LIM = 2;

    localparam logic [DATA_W-1:0] POISON = 32'hBADBAD00;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              owner;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_LAT   (MEM_LAT),
        .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        case (a)
            32'h10:  return 32'hDEADBEEF;
            32'h20:  return 32'h2020CAFE;
            32'h80:  return 32'h8080F00D;
            default: return {a[15:0], 16'h5A5A};
        endcase
    endfunction

    // Memory model: the address strobed in cycle k is answered in cycle k+MEM_LAT.
    logic              pipe_v    [MEM_LAT];
    logic [ADDR_W-1:0] pipe_addr [MEM_LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) pipe_v[i] <= 1'b0;
        end else begin
            pipe_v[0]    <= mem_en && !mem_we;
            pipe_addr[0] <= mem_addr;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    assign mem_rdata = (pipe_v[MEM_LAT-1] === 1'b1) ? mem_word(pipe_addr[MEM_LAT-1]) : POISON;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_owner [6];

        rst     = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        step(2);

        // Reset state.
        check("rst_busy",     busy,      1'b0);
        check("rst_owner",    owner,     1'b0);
        check("rst_mem_en",   mem_en,    1'b0);
        check("rst_mem_we",   mem_we,    1'b0);
        check("rst_mem_addr", mem_addr,  32'h0);
        check("rst_ready",    {if_ready, d_ready}, 2'b00);
        check("rst_rdata",    {if_rdata, d_rdata}, 64'h0);
        rst = 1'b0;
        step(1);

        // Single fetch.
        if_req = 1'b1; if_addr = 32'h10;                         // cycle 0
        check("f_idle_busy", busy, 1'b0);
        step(1);                                                 // cycle 1
        check("f_issue_en",   mem_en,   1'b1);
        check("f_issue_we",   mem_we,   1'b0);
        check("f_issue_addr", mem_addr, 32'h10);
        check("f_issue_busy", busy,     1'b1);
        check("f_owner",      owner,    1'b0);
        step(1);                                                 // cycle 2
        check("f_c2_en",    mem_en,   1'b0);
        check("f_c2_ready", if_ready, 1'b0);
        check("f_c2_busy",  busy,     1'b1);
        step(1);                                                 // cycle 3
        check("f_c3_ready", if_ready, 1'b0);
        check("f_c3_busy",  busy,     1'b1);
        step(1);                                                 // cycle 4
        check("f_done_ready", if_ready, 1'b1);
        check("f_done_dready", d_ready, 1'b0);
        check("f_done_rdata", if_rdata, 32'hDEADBEEF);
        check("f_done_busy",  busy,     1'b1);
        step(1);                                                 // cycle 5
        if_req = 1'b0;
        check("f_c5_ready", if_ready, 1'b0);
        check("f_c5_busy",  busy,     1'b0);
        step(1);                                                 // cycle 6
        check("f_c6_en", mem_en, 1'b0);

        // Simultaneous requests: D first, then IF.
        if_req = 1'b1; if_addr = 32'h20;                         // cycle 0
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        step(1);                                                 // cycle 1
        check("s_d_en",    mem_en,   1'b1);
        check("s_d_addr",  mem_addr, 32'h80);
        check("s_d_owner", owner,    1'b1);
        step(3);                                                 // cycle 4
        check("s_d_ready",  d_ready,  1'b1);
        check("s_d_ifrdy",  if_ready, 1'b0);
        check("s_d_rdata",  d_rdata,  32'h8080F00D);
        check("s_d_ifdata", if_rdata, 32'hDEADBEEF);
        step(1);                                                 // cycle 5
        d_req = 1'b0;
        check("s_c5_en", mem_en, 1'b0);
        step(1);                                                 // cycle 6
        check("s_if_en",    mem_en,   1'b1);
        check("s_if_addr",  mem_addr, 32'h20);
        check("s_if_owner", owner,    1'b0);
        step(3);                                                 // cycle 9
        check("s_if_ready", if_ready, 1'b1);
        check("s_if_drdy",  d_ready,  1'b0);
        check("s_if_rdata", if_rdata, 32'h2020CAFE);
        step(1);                                                 // cycle 10
        if_req = 1'b0;
        step(1);

        // Write; wdata change during the transaction must not leak through.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h1234;  // cycle 0
        step(1);                                                 // cycle 1
        d_wdata = 32'hFFFF; d_addr = 32'h99;
        check("w_en",    mem_en,    1'b1);
        check("w_we",    mem_we,    1'b1);
        check("w_addr",  mem_addr,  32'h44);
        check("w_wdata", mem_wdata, 32'h1234);
        step(1);                                                 // cycle 2
        check("w_c2_we",    mem_we,    1'b0);
        check("w_c2_wdata", mem_wdata, 32'h1234);
        check("w_c2_addr",  mem_addr,  32'h44);
        step(2);                                                 // cycle 4
        check("w_ready", d_ready, 1'b1);
        check("w_rdata", d_rdata, 32'h8080F00D);
        step(1);                                                 // cycle 5
        d_req = 1'b0; d_we = 1'b0;
        step(1);

        // Starvation: both held; grant order D, D, IF, D, D, IF.
        exp_owner = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        if_req = 1'b1; if_addr = 32'h20;                         // cycle 0
        d_req  = 1'b1; d_addr  = 32'h80;
        step(1);                                                 // cycle 1: first issue
        for (int i = 0; i < 6; i++) begin
            check($sformatf("st_owner%0d", i), owner,  exp_owner[i]);
            check($sformatf("st_en%0d", i),    mem_en, 1'b1);
            check($sformatf("st_addr%0d", i),  mem_addr, exp_owner[i] ? 32'h80 : 32'h20);
            step(3);                                             // done cycle
            check($sformatf("st_rdy%0d", i), {if_ready, d_ready},
                  exp_owner[i] ? 2'b01 : 2'b10);
            step(2);                                             // next issue cycle
        end
        if_req = 1'b0; d_req = 1'b0;   // overshot by one issue; let it drain
        step(5);
        check("st_drain_busy", busy, 1'b0);

        // Reset mid-fetch, fetch re-issues afterwards.
        if_req = 1'b1; if_addr = 32'h10;                         // cycle 0
        step(2);                                                 // cycle 2
        rst = 1'b1;
        step(1);                                                 // cycle 3
        rst = 1'b0;
        check("r_busy",  busy,     1'b0);
        check("r_en",    mem_en,   1'b0);
        check("r_addr",  mem_addr, 32'h0);
        check("r_owner", owner,    1'b0);
        check("r_rdata", {if_rdata, d_rdata}, 64'h0);
        check("r_ready", {if_ready, d_ready}, 2'b00);
        step(1);                                                 // cycle 4
        check("r_c4_ready", if_ready, 1'b0);
        check("r_reissue",  mem_en,   1'b1);
        check("r_re_addr",  mem_addr, 32'h10);
        step(3);                                                 // cycle 7
        check("r_re_ready", if_ready, 1'b1);
        check("r_re_rdata", if_rdata, 32'hDEADBEEF);
        step(1);
        if_req = 1'b0;
        step(1);

        // Flush: request dropped mid-transaction still completes.
        if_req = 1'b1; if_addr = 32'h30;                         // cycle 0
        step(2);                                                 // cycle 2
        if_req = 1'b0;
        step(2);                                                 // cycle 4
        check("fl_ready", if_ready, 1'b1);
        check("fl_rdata", if_rdata, 32'h00305A5A);
        step(1);                                                 // cycle 5
        check("fl_c5_busy", busy, 1'b0);
        step(1);                                                 // cycle 6
        check("fl_c6_en",   mem_en, 1'b0);
        check("fl_c6_busy", busy,   1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Mutual exclusion of the ready pulses, checked on every cycle.
    always @(negedge clk) begin
        if (!rst && if_ready && d_ready) begin
            check("ready_excl", {if_ready, d_ready}, 2'b00);
        end
    end

endmodule
